// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-port synchronous data memory.
package dmem_pkg;

  typedef enum logic {CLEAR, RUN} dmem_state_e;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned BYTES_PER_WORD     = DATA_WIDTH_DEFAULT / 8;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MAX_DATA_WIDTH = 512;
  localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] data,
    input logic [MAX_BYTES-1:0]      be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (be[b]) merged[b*8 +: 8] = data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// CLEAR/RUN state machine: walks every word once after reset, then raises ready.
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam dmem_state_e ResetState = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  dmem_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      ready_q <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          // Last word is written on this edge, so ready rises with it.
          if (cnt_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/dmem_mp_sync.sv
// Multi-port synchronous data memory with byte enables and post-reset clear.
// Define DMEM_WRITE_FIRST_EN for write-first (forwarding) read-during-write.
module dmem_mp_sync
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              rd_en,
  input  logic [NUM_PORTS-1:0]              wr_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata,
  output logic [NUM_PORTS-1:0]              rvalid,
  output logic                              ready
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] rd_word [NUM_PORTS];

  dmem_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Byte-wise writes in ascending port order: the highest port wins each byte.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (ready) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (wr_en[p] && be[p*NumBytes + b]) begin
            mem_q[addr[p*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <=
              wdata[p*DATA_WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word[p] = mem_q[addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef DMEM_WRITE_FIRST_EN
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (ready && wr_en[q] &&
            addr[q*ADDR_WIDTH +: ADDR_WIDTH] == addr[p*ADDR_WIDTH +: ADDR_WIDTH]) begin
          rd_word[p] = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(rd_word[p]),
                                              MAX_DATA_WIDTH'(wdata[q*DATA_WIDTH +: DATA_WIDTH]),
                                              MAX_BYTES'(be[q*NumBytes +: NumBytes])));
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rvalid[p] <= ready && rd_en[p];
        if (ready && rd_en[p]) rdata[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
      end
    end
  end

endmodule
